match_controller: RTL and testbench

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/match_pkg.sv | 27 ++
 rtl/bcd2_counter.sv | 73 +++++++
 rtl/match_controller.sv | 146 ++++++++++++++
 tb/tb_match_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared definitions for the match controller.
// Contents:
//   - state encoding for the match flow
//   - default match and countdown lengths
//   - a helper that turns a seconds value (0..99) into two BCD digits
package match_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READY  = 2'd1,
      ST_PLAY   = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   localparam int unsigned MATCH_SEC_DEF = 60;
   localparam int unsigned READY_SEC_DEF = 3;

   // Convert 0..99 seconds into {tens, ones} BCD digits.
   function automatic logic [7:0] sec_to_bcd(input int unsigned sec);
      logic [3:0] tens_v;
      logic [3:0] ones_v;
      tens_v = 4'(sec / 32'd10);
      ones_v = 4'(sec % 32'd10);
      return {tens_v, ones_v};
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   load_i, load_tens_i/ones_i - synchronous load (highest priority)
//   inc_i                     - increment, saturates at 99
//   dec_i                     - decrement, stops at 00
//   tens_o, ones_o            - registered BCD digits
module bcd2_counter #(
   parameter logic [3:0] RST_TENS = 4'd0,
   parameter logic [3:0] RST_ONES = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [3:0] load_tens_i,
   input  logic [3:0] load_ones_i,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;

   // Next-digit logic: load, then saturating increment, then floored decrement.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (load_i) begin
         tens_d = load_tens_i;
         ones_d = load_ones_i;
      end else if (inc_i) begin
         if ((tens_q == 4'd9) && (ones_q == 4'd9)) begin
            tens_d = tens_q;
            ones_d = ones_q;
         end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end else if (dec_i) begin
         if ((tens_q == 4'd0) && (ones_q == 4'd0)) begin
            tens_d = tens_q;
            ones_d = ones_q;
         end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
         end else begin
            ones_d = ones_q - 4'd1;
         end
      end else begin
         tens_d = tens_q;
         ones_d = ones_q;
      end
   end

   // Digit registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens_q <= RST_TENS;
         ones_q <= RST_ONES;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens_o = tens_q;
   assign ones_o = ones_q;

endmodule

// File: rtl/match_controller.sv
// Match controller: IDLE -> READY countdown -> PLAY (score + clock) -> FINISH.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   tick                     - 1 Hz single-cycle enable
//   start_p, goal_p          - debounced single-cycle button/sensor pulses
//   score_tens/ones          - BCD score digits
//   time_tens/ones           - BCD displayed seconds
//   state                    - 0 IDLE, 1 READY, 2 PLAY, 3 FINISH
//   finished                 - high while in FINISH
// Every output comes straight from a flop; pulses are judged only by the
// state that is current when they arrive.
module match_controller
   import match_pkg::*;
#(
   parameter int unsigned MATCH_SEC = MATCH_SEC_DEF,
   parameter int unsigned READY_SEC = READY_SEC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start_p,
   input  logic       goal_p,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic [3:0] time_ones,
   output logic [3:0] time_tens,
   output logic [1:0] state,
   output logic       finished
);

   localparam logic [7:0] MATCH_BCD = sec_to_bcd(MATCH_SEC);
   localparam logic [7:0] READY_BCD = sec_to_bcd(READY_SEC);

   state_e     state_q, state_d;
   logic       finished_q, finished_d;
   logic       score_load_s, score_inc_s;
   logic       time_load_s, time_dec_s;
   logic [7:0] time_load_val_s;
   logic       time_is_one_s;

   assign time_is_one_s = (time_tens == 4'd0) && (time_ones == 4'd1);

   // Next-state and counter control, decided from the current state only.
   always_comb begin
      state_d         = state_q;
      score_load_s    = 1'b0;
      score_inc_s     = 1'b0;
      time_load_s     = 1'b0;
      time_dec_s      = 1'b0;
      time_load_val_s = MATCH_BCD;
      case (state_q)
         ST_IDLE: begin
            if (start_p) begin
               score_load_s    = 1'b1;
               time_load_s     = 1'b1;
               time_load_val_s = READY_BCD;
               state_d         = ST_READY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READY: begin
            if (tick && time_is_one_s) begin
               time_load_s     = 1'b1;
               time_load_val_s = MATCH_BCD;
               state_d         = ST_PLAY;
            end else if (tick) begin
               time_dec_s = 1'b1;
            end else begin
               state_d = ST_READY;
            end
         end
         ST_PLAY: begin
            score_inc_s = goal_p;
            if (tick && time_is_one_s) begin
               time_load_s     = 1'b1;
               time_load_val_s = 8'h00;
               state_d         = ST_FINISH;
            end else if (tick) begin
               time_dec_s = 1'b1;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_FINISH: begin
            if (start_p) begin
               score_load_s    = 1'b1;
               time_load_s     = 1'b1;
               time_load_val_s = MATCH_BCD;
               state_d         = ST_IDLE;
            end else begin
               state_d = ST_FINISH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      finished_d = (state_d == ST_FINISH);
   end

   // State and finished-flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         finished_q <= finished_d;
      end
   end

   bcd2_counter #(
      .RST_TENS (4'd0),
      .RST_ONES (4'd0)
   ) u_score (
      .clk         (clk),
      .rst         (rst),
      .load_i      (score_load_s),
      .load_tens_i (4'd0),
      .load_ones_i (4'd0),
      .inc_i       (score_inc_s),
      .dec_i       (1'b0),
      .tens_o      (score_tens),
      .ones_o      (score_ones)
   );

   bcd2_counter #(
      .RST_TENS (MATCH_BCD[7:4]),
      .RST_ONES (MATCH_BCD[3:0])
   ) u_time (
      .clk         (clk),
      .rst         (rst),
      .load_i      (time_load_s),
      .load_tens_i (time_load_val_s[7:4]),
      .load_ones_i (time_load_val_s[3:0]),
      .inc_i       (1'b0),
      .dec_i       (time_dec_s),
      .tens_o      (time_tens),
      .ones_o      (time_ones)
   );

   assign state    = state_q;
   assign finished = finished_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with MATCH_SEC=10, READY_SEC=3.
// Observed vector layout: {state[1:0], score tens/ones, time tens/ones, finished}.
module tb_match_controller;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       start_p;
   logic       goal_p;
   logic [3:0] score_ones, score_tens, time_ones, time_tens;
   logic [1:0] state;
   logic       finished;

   int checks;
   int errors;

   logic [18:0] obs;
   logic [18:0] exp;

   assign obs = {state, score_tens, score_ones, time_tens, time_ones, finished};

   match_controller #(
      .MATCH_SEC (10),
      .READY_SEC (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start_p    (start_p),
      .goal_p     (goal_p),
      .score_ones (score_ones),
      .score_tens (score_tens),
      .time_ones  (time_ones),
      .time_tens  (time_tens),
      .state      (state),
      .finished   (finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle pulse on the chosen inputs; returns at the following negedge.
   task automatic drive(input logic t, input logic g, input logic s);
      @(negedge clk);
      tick    = t;
      goal_p  = g;
      start_p = s;
      @(negedge clk);
      tick    = 1'b0;
      goal_p  = 1'b0;
      start_p = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp = {2'd0, 8'h00, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_state got %h exp %h", obs, exp);
      end
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL idle_ignores_tick_goal got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_ready();
      // tick in the same cycle as start must not count down yet
      drive(1'b1, 1'b0, 1'b1);
      exp = {2'd1, 8'h00, 8'h03, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ready_entry got %h exp %h", obs, exp);
      end
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      exp = {2'd1, 8'h00, 8'h02, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ready_tick_ignore got %h exp %h", obs, exp);
      end
      drive(1'b1, 1'b0, 1'b0);
      exp = {2'd1, 8'h00, 8'h01, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ready_one got %h exp %h", obs, exp);
      end
      drive(1'b1, 1'b1, 1'b0);
      exp = {2'd2, 8'h00, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ready_to_play got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_goals();
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
      exp = {2'd2, 8'h10, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL score_carry got %h exp %h", obs, exp);
      end
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      exp = {2'd2, 8'h12, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL score_12 got %h exp %h", obs, exp);
      end
      for (int i = 0; i < 93; i++) drive(1'b0, 1'b1, 1'b0);
      exp = {2'd2, 8'h99, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL score_saturate got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_final_tick();
      do_reset();
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      exp = {2'd2, 8'h04, 8'h09, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL time_borrow got %h exp %h", obs, exp);
      end
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0);
      exp = {2'd2, 8'h04, 8'h01, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL time_one got %h exp %h", obs, exp);
      end
      drive(1'b1, 1'b1, 1'b0);
      exp = {2'd3, 8'h05, 8'h00, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL final_tick_goal got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_finish();
      drive(1'b1, 1'b1, 1'b0);
      exp = {2'd3, 8'h05, 8'h00, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL finish_freeze got %h exp %h", obs, exp);
      end
      drive(1'b0, 1'b0, 1'b1);
      exp = {2'd0, 8'h00, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL finish_to_idle got %h exp %h", obs, exp);
      end
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      exp = {2'd3, 8'h07, 8'h00, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL finish_score7 got %h exp %h", obs, exp);
      end
      // all three together: only start matters in FINISH, goal not counted in IDLE
      drive(1'b1, 1'b1, 1'b1);
      exp = {2'd0, 8'h00, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL finish_all_pulses got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      exp = {2'd2, 8'h03, 8'h09, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL pre_reset_play got %h exp %h", obs, exp);
      end
      #2;
      rst = 1'b1;
      #1;
      exp = {2'd0, 8'h00, 8'h10, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL async_reset got %h exp %h", obs, exp);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL idle_after_reset got %h exp %h", obs, exp);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      tick    = 1'b0;
      start_p = 1'b0;
      goal_p  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_ready();
      test_goals();
      test_final_tick();
      test_finish();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
